sarray_mem_resp: RTL and testbench

- Memory-side responder for the systolic-array load/store channels. Serves single-beat AR read requests with R data beats, and accepts single-beat AW writes that carry address and data together.
- Backed by one single-port synchronous line store: one read or one write per cycle.
- Sits between the array controller's ar/r/aw ports and the on-chip scratchpad. It is also the reference slave model in block-level benches.

---
 rtl/sarray_mem_resp_pkg.sv | 23 ++
 rtl/sarray_mem_resp_spad_line_sram.sv | 34 +++
 rtl/sarray_mem_resp.sv | 180 ++++++++++++++++++
 tb/tb_sarray_mem_resp.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sarray_mem_resp_pkg.sv
// ---- sarray_mem_resp_pkg : shared widths and arbitration encoding (rev 1.0) ----
`default_nettype none

package sarray_mem_resp_pkg;

   localparam int SARRAY_ADDR_WIDTH      = 64;
   localparam int SARRAY_LOAD_WIDTH      = 2048;
   localparam int SARRAY_STORE_WIDTH     = 2048;
   localparam int SARRAY_LINE_BYTES_LOG2 = 8;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_READ  = 2'd1,
      GNT_WRITE = 2'd2
   } grant_e;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sarray_mem_resp_spad_line_sram.sv
// ---- spad_line_sram : single-port synchronous line store, rdata valid the cycle after a read (rev 1.0) ----
`default_nettype none

module spad_line_sram
   import sarray_mem_resp_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int WIDTH = SARRAY_LOAD_WIDTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // rdata only moves on a read, so a pending beat survives interleaved writes
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sarray_mem_resp.sv
// ---- sarray_mem_resp : memory-side responder for the systolic-array ar/r/aw channels (rev 1.0) ----
`default_nettype none

module sarray_mem_resp
   import sarray_mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH    = SARRAY_ADDR_WIDTH,
   parameter int LOAD_WIDTH    = SARRAY_LOAD_WIDTH,
   parameter int STORE_WIDTH   = SARRAY_STORE_WIDTH,
   parameter int LINE_DEPTH    = 1024,
   parameter int AR_FIFO_DEPTH = 4,
   parameter int WR_STREAK_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sarray_ar_valid_i,
   output logic                   sarray_ar_ready_o,
   input  logic [ADDR_WIDTH-1:0]  sarray_ar_addr_i,
   output logic                   sarray_r_valid_o,
   input  logic                   sarray_r_ready_i,
   output logic [LOAD_WIDTH-1:0]  sarray_r_data_o,
   input  logic                   sarray_aw_valid_i,
   output logic                   sarray_aw_ready_o,
   input  logic [ADDR_WIDTH-1:0]  sarray_aw_addr_i,
   input  logic [STORE_WIDTH-1:0] sarray_aw_data_i,
   output logic                   busy_o
);

   localparam int IDX_W    = $clog2(LINE_DEPTH);
   localparam int PTR_W    = $clog2(AR_FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STREAK_W = $clog2(WR_STREAK_MAX + 1);

   generate
      if (STORE_WIDTH != LOAD_WIDTH) begin : g_width_check
         $error("sarray_mem_resp: STORE_WIDTH must equal LOAD_WIDTH");
      end
      if (!is_pow2(LINE_DEPTH) || !is_pow2(AR_FIFO_DEPTH) || AR_FIFO_DEPTH < 2) begin : g_depth_check
         $error("sarray_mem_resp: LINE_DEPTH and AR_FIFO_DEPTH must be powers of two, AR_FIFO_DEPTH >= 2");
      end
   endgenerate

   logic [IDX_W-1:0]    ar_fifo [AR_FIFO_DEPTH];
   logic [PTR_W-1:0]    ar_wr_ptr, ar_rd_ptr;
   logic [CNT_W-1:0]    ar_count;
   logic                ar_nonempty, ar_push;
   logic [IDX_W-1:0]    ar_idx, aw_idx;
   logic [STREAK_W-1:0] wr_streak;
   logic                inflight, read_credit;
   grant_e              grant;
   logic [LOAD_WIDTH-1:0] rbuf [2];
   logic                rbuf_head, rbuf_tail;
   logic [1:0]          rbuf_count;
   logic                rbuf_push, rbuf_pop, bypass;
   logic                sram_en, sram_we;
   logic [IDX_W-1:0]    sram_idx;
   logic [LOAD_WIDTH-1:0] sram_rdata;
   logic                unused_addr_bits;

   assign ar_idx           = sarray_ar_addr_i[SARRAY_LINE_BYTES_LOG2 +: IDX_W];
   assign aw_idx           = sarray_aw_addr_i[SARRAY_LINE_BYTES_LOG2 +: IDX_W];
   assign unused_addr_bits = ^{sarray_ar_addr_i, sarray_aw_addr_i};

   assign ar_nonempty       = (ar_count != '0);
   assign sarray_ar_ready_o = (ar_count != CNT_W'(AR_FIFO_DEPTH));
   assign ar_push           = sarray_ar_valid_i & sarray_ar_ready_o;

   // inflight counts as an occupied slot: its line lands in the SRAM output register
   assign read_credit = ({1'b0, rbuf_count} + {2'b00, inflight}) < 3'd2;
   assign sarray_aw_ready_o =
      ~((wr_streak == STREAK_W'(WR_STREAK_MAX)) & ar_nonempty & read_credit);

   always_comb begin
      grant = GNT_IDLE;
      if (sarray_aw_valid_i && sarray_aw_ready_o) begin
         grant = GNT_WRITE;
      end else if (ar_nonempty && read_credit) begin
         grant = GNT_READ;
      end
   end

   assign sram_en  = (grant != GNT_IDLE);
   assign sram_we  = (grant == GNT_WRITE);
   assign sram_idx = sram_we ? aw_idx : ar_fifo[ar_rd_ptr];

   spad_line_sram #(
      .DEPTH (LINE_DEPTH),
      .WIDTH (LOAD_WIDTH),
      .IDX_W (IDX_W)
   ) u_sram (
      .clk   (clk),
      .en    (sram_en),
      .we    (sram_we),
      .idx   (sram_idx),
      .wdata (sarray_aw_data_i),
      .rdata (sram_rdata)
   );

   always_ff @(posedge clk) begin
      if (ar_push) begin
         ar_fifo[ar_wr_ptr] <= ar_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_wr_ptr <= '0;
         ar_rd_ptr <= '0;
         ar_count  <= '0;
         wr_streak <= '0;
         inflight  <= 1'b0;
      end else begin
         if (ar_push) begin
            ar_wr_ptr <= ar_wr_ptr + 1'b1;
         end
         if (grant == GNT_READ) begin
            ar_rd_ptr <= ar_rd_ptr + 1'b1;
         end
         case ({ar_push, grant == GNT_READ})
            2'b10:   ar_count <= ar_count + 1'b1;
            2'b01:   ar_count <= ar_count - 1'b1;
            default: ar_count <= ar_count;
         endcase
         if (!ar_nonempty || grant == GNT_READ) begin
            wr_streak <= '0;
         end else if (grant == GNT_WRITE && wr_streak != STREAK_W'(WR_STREAK_MAX)) begin
            wr_streak <= wr_streak + 1'b1;
         end
         inflight <= (grant == GNT_READ);
      end
   end

   // An inflight beat with an empty buffer is presented straight from the SRAM
   // output register; it only enters the buffer if not consumed this cycle.
   assign bypass    = inflight & (rbuf_count == 2'd0) & sarray_r_ready_i;
   assign rbuf_push = inflight & ~bypass;
   assign rbuf_pop  = (rbuf_count != 2'd0) & sarray_r_ready_i;

   always_ff @(posedge clk) begin
      if (rbuf_push) begin
         rbuf[rbuf_tail] <= sram_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbuf_head  <= 1'b0;
         rbuf_tail  <= 1'b0;
         rbuf_count <= 2'd0;
      end else begin
         if (rbuf_push) begin
            rbuf_tail <= ~rbuf_tail;
         end
         if (rbuf_pop) begin
            rbuf_head <= ~rbuf_head;
         end
         case ({rbuf_push, rbuf_pop})
            2'b10:   rbuf_count <= rbuf_count + 2'd1;
            2'b01:   rbuf_count <= rbuf_count - 2'd1;
            default: rbuf_count <= rbuf_count;
         endcase
      end
   end

   assign sarray_r_valid_o = (rbuf_count != 2'd0) | inflight;

   always_comb begin
      sarray_r_data_o = '0;
      if (rbuf_count != 2'd0) begin
         sarray_r_data_o = rbuf[rbuf_head];
      end else if (inflight) begin
         sarray_r_data_o = sram_rdata;
      end
   end

   assign busy_o = ar_nonempty | inflight | (rbuf_count != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_sarray_mem_resp.sv
// ---- tb_sarray_mem_resp : directed self-checking bench for sarray_mem_resp (rev 1.0) ----
`default_nettype none

module tb_sarray_mem_resp;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ar_valid = 1'b0;
   logic          ar_ready;
   logic [63:0]   ar_addr = '0;
   logic          r_valid;
   logic          r_ready = 1'b0;
   logic [2047:0] r_data;
   logic          aw_valid = 1'b0;
   logic          aw_ready;
   logic [63:0]   aw_addr = '0;
   logic [2047:0] aw_data = '0;
   logic          busy;

   int num_checks = 0;
   int num_errors = 0;

   always #5 clk = ~clk;

   sarray_mem_resp dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .sarray_ar_valid_i (ar_valid),
      .sarray_ar_ready_o (ar_ready),
      .sarray_ar_addr_i  (ar_addr),
      .sarray_r_valid_o  (r_valid),
      .sarray_r_ready_i  (r_ready),
      .sarray_r_data_o   (r_data),
      .sarray_aw_valid_i (aw_valid),
      .sarray_aw_ready_o (aw_ready),
      .sarray_aw_addr_i  (aw_addr),
      .sarray_aw_data_i  (aw_data),
      .busy_o            (busy)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [2047:0] line_pat(input int n);
      logic [2047:0] p;
      for (int k = 0; k < 32; k++) begin
         p[k*64 +: 64] = {16'hA5C3, 16'(k), 32'(n)};
      end
      return p;
   endfunction

   function automatic logic [63:0] fold(input logic [2047:0] d);
      logic [63:0] f = '0;
      for (int k = 0; k < 32; k++) begin
         f = f ^ d[k*64 +: 64];
      end
      return f;
   endfunction

   task automatic check_line(input string tag, input logic [2047:0] got, input logic [2047:0] exp);
      check_val({tag, "_lo"}, got[63:0], exp[63:0]);
      check_val({tag, "_fold"}, fold(got), fold(exp));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_line(input logic [63:0] addr, input logic [2047:0] data);
      int n = 0;
      aw_valid = 1'b1;
      aw_addr  = addr;
      aw_data  = data;
      #1;
      while (!aw_ready && n < 20) begin
         tick();
         n++;
      end
      if (!aw_ready) check_val("wr_accept_timeout", 64'(aw_ready), 64'd1);
      tick();
      aw_valid = 1'b0;
   endtask

   task automatic read_line(input logic [63:0] addr, input logic [2047:0] exp,
                            input string tag, output int lat);
      int n = 0;
      ar_valid = 1'b1;
      ar_addr  = addr;
      #1;
      while (!ar_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      ar_valid = 1'b0;
      lat = 1;
      #1;
      while (!r_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!r_valid) check_val({tag, "_timeout"}, 64'(r_valid), 64'd1);
      else check_line(tag, r_data, exp);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      #1;
   endtask

   // 64 reads of lines 0..63; r_ready held low for the first `hold` cycles
   task automatic stream(input int hold, input string tag);
      int issued = 0;
      int beats = 0;
      int ar_drops = 0;
      for (int c = 0; c < 400 && beats < 64; c++) begin
         ar_valid = (issued < 64);
         ar_addr  = 64'(issued) * 64'h100;
         r_ready  = (c >= hold);
         #1;
         if (hold == 0 && c < 64 && !ar_ready) ar_drops++;
         if (hold > 0 && c == 9)  check_val({tag, "_ar_ready_full"}, 64'(ar_ready), 64'd0);
         if (hold > 0 && c == 9)  check_val({tag, "_busy"}, 64'(busy), 64'd1);
         if (hold > 0 && c == 9)  check_line({tag, "_held_head"}, r_data, line_pat(0));
         if (hold > 0 && c == 11) check_val({tag, "_full_pop_no_ready"}, 64'(ar_ready), 64'd0);
         if (r_valid && r_ready) begin
            check_line($sformatf("%s_beat%0d", tag, beats), r_data, line_pat(beats));
            if (hold == 0) check_val($sformatf("%s_cycle%0d", tag, beats), 64'(c), 64'(beats + 2));
            beats++;
         end
         if (ar_valid && ar_ready) issued++;
         tick();
      end
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      #1;
      check_val({tag, "_beats"}, 64'(beats), 64'd64);
      if (hold == 0) check_val({tag, "_ar_drops"}, 64'(ar_drops), 64'd0);
      check_val({tag, "_no_extra_beat"}, 64'(r_valid), 64'd0);
      check_val({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic [2047:0] a5_line;
      int lat;
      int post_beats;

      a5_line = {256{8'hA5}};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_val("rst_ar_ready", 64'(ar_ready), 64'd1);
      check_val("rst_r_valid", 64'(r_valid), 64'd0);
      check_val("rst_r_data", r_data[63:0], 64'd0);
      check_val("rst_aw_ready", 64'(aw_ready), 64'd1);
      check_val("rst_busy", 64'(busy), 64'd0);

      write_line(64'h0, a5_line);
      read_line(64'h0, a5_line, "rd_a5", lat);
      check_val("rd_a5_latency", 64'(lat), 64'd2);
      read_line(64'h10, a5_line, "rd_a5_offset", lat);

      for (int n = 0; n < 64; n++) begin
         write_line(64'(n) * 64'h100, line_pat(n));
      end
      stream(0, "thru");
      stream(10, "bp");

      // streak: one AR to line 5 pending while writes to line 5 keep arriving
      for (int c = 0; c < 7; c++) begin
         ar_valid = (c == 0);
         ar_addr  = 64'h500;
         aw_valid = (c < 6);
         aw_addr  = 64'h500;
         aw_data  = line_pat(1000 + c);
         r_ready  = (c == 6);
         #1;
         if (c < 5)  check_val($sformatf("streak_aw_ready_c%0d", c), 64'(aw_ready), 64'd1);
         if (c == 5) check_val("streak_aw_block", 64'(aw_ready), 64'd0);
         if (c == 6) begin
            check_val("streak_aw_reopen", 64'(aw_ready), 64'd1);
            check_val("streak_r_valid", 64'(r_valid), 64'd1);
            check_line("streak_rd_sees_write", r_data, line_pat(1004));
         end
         tick();
      end
      r_ready = 1'b0;

      read_line(64'h40100, line_pat(1), "alias_depth", lat);
      read_line(64'hF000_0000_0000_0110, line_pat(1), "alias_upper", lat);

      // reset with reads queued and buffered
      for (int c = 0; c < 3; c++) begin
         ar_valid = 1'b1;
         ar_addr  = 64'(c + 10) * 64'h100;
         tick();
      end
      ar_valid = 1'b0;
      #2;
      check_val("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_ar_ready", 64'(ar_ready), 64'd1);
      check_val("mid_rst_r_valid", 64'(r_valid), 64'd0);
      check_val("mid_rst_r_data", r_data[63:0], 64'd0);
      check_val("mid_rst_aw_ready", 64'(aw_ready), 64'd1);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r_ready = 1'b1;
      post_beats = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (r_valid) post_beats++;
      end
      r_ready = 1'b0;
      check_val("post_rst_beats", 64'(post_beats), 64'd0);
      check_val("post_rst_busy", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
